instr_read_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the core's fetch port and the system bus. It serves word reads from an external dual-ported cache store and keeps tags and valid bits internally. On a miss it refills the whole line over the bus master port, then completes the stalled fetch. Writes through the fetch port are not supported.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cache_tag_ram.sv | 41 ++++
 rtl/instr_read_cache.sv | 198 +++++++++++++++++++
 tb/tb_instr_read_cache.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the read-only instruction cache: address fields, bus enums, FSM states.
package cache_pkg;

  localparam int unsigned INDEX_SIZE_DEF   = 4;
  localparam int unsigned DISP_SIZE_DEF    = 6;
  localparam int unsigned TAG_SIZE_DEF     = 22;
  localparam int unsigned WORD_SIZE_DEF    = 32;
  localparam int unsigned MAX_OUTSTANDING  = 4;

  typedef logic [TAG_SIZE_DEF-1:0]   tag_t;
  typedef logic [INDEX_SIZE_DEF-1:0] index_t;
  typedef logic [DISP_SIZE_DEF-1:0]  disp_t;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'd0,
    CMD_WRITE = 3'd1,
    CMD_READ  = 3'd2
  } mcmd_e;

  typedef enum logic [1:0] {
    RESP_NULL = 2'd0,
    RESP_DVA  = 2'd1,
    RESP_FAIL = 2'd2,
    RESP_ERR  = 2'd3
  } sresp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/cache_tag_ram.sv
// Valid + tag array: one combinational read port, one write port, valid bits cleared on reset.
module cache_tag_ram #(
  parameter int unsigned INDEX_SIZE = 4,
  parameter int unsigned TAG_SIZE   = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_SIZE-1:0] rd_index_i,
  output logic                  rd_valid_c,
  output logic [TAG_SIZE-1:0]   rd_tag_c,
  input  logic                  wr_en_i,
  input  logic [INDEX_SIZE-1:0] wr_index_i,
  input  logic                  wr_valid_i,
  input  logic [TAG_SIZE-1:0]   wr_tag_i
);

  localparam int unsigned LINES = 2 ** INDEX_SIZE;

  logic [LINES-1:0]    valid_q;
  logic [TAG_SIZE-1:0] tag_q [LINES];

  // Valid bits: the only state that needs a reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= wr_valid_i;
    end
  end

  // Tag storage, qualified by the valid bit so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  assign rd_valid_c = valid_q[rd_index_i];
  assign rd_tag_c   = tag_q[rd_index_i];

endmodule

// File: rtl/instr_read_cache.sv
// Direct-mapped read-only instruction cache; refills a whole line over the bus on a miss.
module instr_read_cache
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_SIZE        = 4,
  parameter int unsigned DISPLACEMENT_SIZE = 6,
  parameter int unsigned TAG_SIZE          = 22,  // must equal 32 - INDEX_SIZE - DISPLACEMENT_SIZE
  parameter int unsigned WORD_SIZE         = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  // fetch port (slave)
  input  logic                                    read_en_i,
  input  logic                                    read_we_i,
  input  logic [WORD_SIZE/8-1:0]                  read_be_i,
  input  logic [31:0]                             read_addr_i,
  input  logic [WORD_SIZE-1:0]                    read_data_w_i,
  output logic [WORD_SIZE-1:0]                    read_data_r_o,
  output logic                                    read_delay_o,
  // refill bus (master)
  output mcmd_e                                   fetch_mcmd_o,
  output logic [31:0]                             fetch_maddr_o,
  output logic [WORD_SIZE-1:0]                    fetch_mdata_o,
  output logic [WORD_SIZE/8-1:0]                  fetch_mbyteen_o,
  input  logic                                    fetch_scmdaccept_i,
  input  sresp_e                                  fetch_sresp_i,
  input  logic [WORD_SIZE-1:0]                    fetch_sdata_i,
  // store read port: driven in the request cycle so data returns with 1-cycle latency
  output logic                                    store_r_en_o,
  output logic                                    store_r_we_o,
  output logic [WORD_SIZE/8-1:0]                  store_r_be_o,
  output logic [INDEX_SIZE+DISPLACEMENT_SIZE-1:0] store_r_addr_o,
  output logic [WORD_SIZE-1:0]                    store_r_data_w_o,
  input  logic [WORD_SIZE-1:0]                    store_r_data_r_i,
  // store write port (refill data)
  output logic                                    store_w_en_o,
  output logic                                    store_w_we_o,
  output logic [WORD_SIZE/8-1:0]                  store_w_be_o,
  output logic [INDEX_SIZE+DISPLACEMENT_SIZE-1:0] store_w_addr_o,
  output logic [WORD_SIZE-1:0]                    store_w_data_w_o
);

  localparam int unsigned WORDS = 2 ** DISPLACEMENT_SIZE;
  localparam int unsigned CNT_W = DISPLACEMENT_SIZE + 1;
  localparam int unsigned SA_W  = INDEX_SIZE + DISPLACEMENT_SIZE;

  state_e                      state_q;
  logic                        delay_q;
  logic [WORD_SIZE-1:0]        data_q;
  mcmd_e                       mcmd_q;
  logic [31:0]                 maddr_q;
  logic [WORD_SIZE/8-1:0]      mbyteen_q;
  logic [CNT_W-1:0]            cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]            rsp_cnt_q, rsp_cnt_d;
  logic [TAG_SIZE-1:0]         miss_tag_q;
  logic [INDEX_SIZE-1:0]       miss_index_q;
  logic                        sw_en_q;
  logic [SA_W-1:0]             sw_addr_q;
  logic [WORD_SIZE-1:0]        sw_data_q;

  logic [TAG_SIZE-1:0]          req_tag;
  logic [INDEX_SIZE-1:0]        req_index;
  logic [DISPLACEMENT_SIZE-1:0] req_disp;
  logic                         rd_valid, tag_we, tag_wr_valid;
  logic [TAG_SIZE-1:0]          rd_tag, tag_wr_tag;
  logic [INDEX_SIZE-1:0]        tag_wr_index;
  logic                         req_c, hit_c, miss_c, accept_c, resp_c, can_issue_c;
  logic                         unused_c;

  assign req_tag   = read_addr_i[31 -: TAG_SIZE];
  assign req_index = read_addr_i[DISPLACEMENT_SIZE +: INDEX_SIZE];
  assign req_disp  = read_addr_i[DISPLACEMENT_SIZE-1:0];

  // Writes and byte enables on the fetch port are not supported.
  assign unused_c = ^{read_we_i, read_be_i, read_data_w_i};

  cache_tag_ram #(
    .INDEX_SIZE (INDEX_SIZE),
    .TAG_SIZE   (TAG_SIZE)
  ) u_tag_ram (
    .clk        (clk),
    .rst_n      (reset),
    .rd_index_i (req_index),
    .rd_valid_c (rd_valid),
    .rd_tag_c   (rd_tag),
    .wr_en_i    (tag_we),
    .wr_index_i (tag_wr_index),
    .wr_valid_i (tag_wr_valid),
    .wr_tag_i   (tag_wr_tag)
  );

  // Lookup, refill bookkeeping and tag update decisions.
  always_comb begin
    req_c        = read_en_i && ((state_q == ST_IDLE) || (state_q == ST_LOOKUP));
    hit_c        = rd_valid && (rd_tag == req_tag);
    miss_c       = req_c && !hit_c;
    accept_c     = (mcmd_q == CMD_READ) && fetch_scmdaccept_i;
    resp_c       = (state_q == ST_REFILL) && (fetch_sresp_i == RESP_DVA);
    cmd_cnt_d    = cmd_cnt_q + CNT_W'(accept_c);
    rsp_cnt_d    = rsp_cnt_q + CNT_W'(resp_c);
    can_issue_c  = (cmd_cnt_d < CNT_W'(WORDS)) &&
                   ((cmd_cnt_d - rsp_cnt_d) < CNT_W'(MAX_OUTSTANDING));
    // A missing line is invalidated up front so an aborted refill never leaves it valid.
    tag_we       = miss_c || (state_q == ST_FINISH);
    tag_wr_valid = (state_q == ST_FINISH);
    tag_wr_index = (state_q == ST_FINISH) ? miss_index_q : req_index;
    tag_wr_tag   = (state_q == ST_FINISH) ? miss_tag_q : req_tag;
  end

  // Controller FSM with registered fetch, bus and store-write outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      delay_q      <= 1'b0;
      data_q       <= '0;
      mcmd_q       <= CMD_IDLE;
      maddr_q      <= '0;
      mbyteen_q    <= '0;
      cmd_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      sw_en_q      <= 1'b0;
      sw_addr_q    <= '0;
      sw_data_q    <= '0;
    end else begin
      sw_en_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOOKUP: begin
          if (!read_en_i) begin
            state_q <= ST_IDLE;
          end else if (hit_c) begin
            data_q  <= store_r_data_r_i;
            delay_q <= 1'b0;
          end else begin
            delay_q      <= 1'b1;
            miss_tag_q   <= req_tag;
            miss_index_q <= req_index;
            cmd_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            mcmd_q       <= CMD_READ;
            maddr_q      <= {req_tag, req_index, DISPLACEMENT_SIZE'(0)};
            mbyteen_q    <= '1;
            state_q      <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          cmd_cnt_q <= cmd_cnt_d;
          rsp_cnt_q <= rsp_cnt_d;
          if (resp_c) begin
            sw_en_q   <= 1'b1;
            sw_addr_q <= {miss_index_q, rsp_cnt_q[DISPLACEMENT_SIZE-1:0]};
            sw_data_q <= fetch_sdata_i;
          end
          // A presented command is held until accepted.
          if (accept_c || (mcmd_q != CMD_READ)) begin
            if (can_issue_c) begin
              mcmd_q    <= CMD_READ;
              maddr_q   <= {miss_tag_q, miss_index_q, cmd_cnt_d[DISPLACEMENT_SIZE-1:0]};
              mbyteen_q <= '1;
            end else begin
              mcmd_q    <= CMD_IDLE;
              maddr_q   <= '0;
              mbyteen_q <= '0;
            end
          end
          if (rsp_cnt_d == CNT_W'(WORDS)) begin
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_q <= ST_LOOKUP;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_data_r_o    = data_q;
  assign read_delay_o     = delay_q;
  assign fetch_mcmd_o     = mcmd_q;
  assign fetch_maddr_o    = maddr_q;
  assign fetch_mdata_o    = '0;
  assign fetch_mbyteen_o  = mbyteen_q;
  assign store_r_en_o     = req_c;
  assign store_r_we_o     = 1'b0;
  assign store_r_be_o     = '1;
  assign store_r_addr_o   = {req_index, req_disp};
  assign store_r_data_w_o = '0;
  assign store_w_en_o     = sw_en_q;
  assign store_w_we_o     = sw_en_q;
  assign store_w_be_o     = {(WORD_SIZE/8){sw_en_q}};
  assign store_w_addr_o   = sw_addr_q;
  assign store_w_data_w_o = sw_data_q;

endmodule

// File: tb/tb_instr_read_cache.sv
// Directed bench for instr_read_cache: memory model returns SData = MAddr.
module tb_instr_read_cache;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read_en = 1'b0;
  logic        read_we = 1'b0;
  logic [3:0]  read_be = 4'h0;
  logic [31:0] read_addr = '0;
  logic [31:0] read_data_w = '0;
  logic [31:0] read_data_r;
  logic        read_delay;
  mcmd_e       mcmd;
  logic [31:0] maddr, mdata;
  logic [3:0]  mbyteen;
  logic        scmdaccept = 1'b0;
  sresp_e      sresp = RESP_NULL;
  logic [31:0] sdata = '0;
  logic        sr_en, sr_we, sw_en, sw_we;
  logic [3:0]  sr_be, sw_be;
  logic [9:0]  sr_addr, sw_addr;
  logic [31:0] sr_wdata, sr_rdata, sw_data;

  logic [31:0] smem [1024];
  logic [31:0] rq [$];
  int unsigned sw_count = 0;
  int unsigned max_q = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        stuck = 1'b0;

  always #5 clk = ~clk;

  instr_read_cache dut (
    .clk(clk), .reset(reset),
    .read_en_i(read_en), .read_we_i(read_we), .read_be_i(read_be),
    .read_addr_i(read_addr), .read_data_w_i(read_data_w),
    .read_data_r_o(read_data_r), .read_delay_o(read_delay),
    .fetch_mcmd_o(mcmd), .fetch_maddr_o(maddr), .fetch_mdata_o(mdata),
    .fetch_mbyteen_o(mbyteen), .fetch_scmdaccept_i(scmdaccept),
    .fetch_sresp_i(sresp), .fetch_sdata_i(sdata),
    .store_r_en_o(sr_en), .store_r_we_o(sr_we), .store_r_be_o(sr_be),
    .store_r_addr_o(sr_addr), .store_r_data_w_o(sr_wdata), .store_r_data_r_i(sr_rdata),
    .store_w_en_o(sw_en), .store_w_we_o(sw_we), .store_w_be_o(sw_be),
    .store_w_addr_o(sw_addr), .store_w_data_w_o(sw_data)
  );

  // External cache store: asynchronous read, synchronous write.
  assign sr_rdata = smem[sr_addr];
  always @(posedge clk) begin
    if (sw_en && sw_we) begin
      smem[sw_addr] <= sw_data;
      sw_count = sw_count + 1;
    end
  end

  // Bus slave: random accept/response, in-order responses, SData = MAddr.
  always @(negedge clk) begin
    if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
      sresp = RESP_DVA;
      sdata = rq.pop_front();
    end else begin
      sresp = RESP_NULL;
      sdata = '0;
    end
    if (mcmd == CMD_READ && $urandom_range(0, 3) != 0) begin
      scmdaccept = 1'b1;
      rq.push_back(maddr);
      if (rq.size() > max_q) max_q = rq.size();
    end else begin
      scmdaccept = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic apply_reset(input int unsigned n);
    read_en = 1'b0;
    reset   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_delay"}, 32'(read_delay), 32'(0));
    check({tag, "_data"}, read_data_r, 32'h0);
    check({tag, "_mcmd"}, 32'(mcmd), 32'(CMD_IDLE));
    check({tag, "_maddr"}, maddr, 32'h0);
    check({tag, "_sw_en"}, 32'(sw_en), 32'(0));
    check({tag, "_sr_en"}, 32'(sr_en), 32'(0));
  endtask

  task automatic do_fetch(input logic [31:0] addr, output logic missed, output logic [31:0] data);
    int unsigned n = 0;
    missed = 1'b0;
    data   = '0;
    if (stuck) return;
    read_addr = addr;
    read_en   = 1'b1;
    @(posedge clk); #1;
    missed = read_delay;
    while (read_delay && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (read_delay) begin
      stuck = 1'b1;
      check("fetch_timeout", 32'(1), 32'(0));
    end
    data = read_data_r;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m;
    logic [31:0] d, a;
    int unsigned misses;
    int unsigned sw_before;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;

    // Linear fetch 0..999: misses only at line starts
    misses = 0;
    for (int i = 0; i < 1000; i++) begin
      do_fetch(32'(i), m, d);
      check("lin_data", d, 32'(i));
      check("lin_miss", 32'(m), 32'((i % 64) == 0));
      if (m) misses++;
    end
    check("lin_refills", 32'(misses), 32'(16));

    // Aliasing on index 0
    apply_reset(2);
    do_fetch(32'h5, m, d);
    check("alias1_miss", 32'(m), 32'(1));
    check("alias1_data", d, 32'h5);
    do_fetch(32'h400, m, d);
    check("alias2_miss", 32'(m), 32'(1));
    check("alias2_data", d, 32'h400);
    do_fetch(32'h5, m, d);
    check("alias3_miss", 32'(m), 32'(1));
    check("alias3_data", d, 32'h5);

    // Random addresses, each immediately re-fetched as a hit
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      do_fetch(a, m, d);
      check("rnd_data", d, a);
      do_fetch(a, m, d);
      check("rnd_rehit", 32'(m), 32'(0));
      check("rnd_rehit_data", d, a);
    end

    // Linear run with random jumps
    a = $urandom;
    for (int i = 0; i < 1000; i++) begin
      do_fetch(a, m, d);
      check("jump_data", d, a);
      a = ($urandom_range(0, 39) == 0) ? $urandom : a + 32'd1;
    end

    // Reset in the middle of a refill of 0x100
    apply_reset(2);
    read_addr = 32'h100;
    read_en   = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrefill_delay", 32'(read_delay), 32'(1));
    read_en = 1'b0;
    reset   = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    sw_before = sw_count;
    repeat (40) @(posedge clk);
    #1;
    check("no_stale_write", 32'(sw_count - sw_before), 32'(0));
    do_fetch(32'h100, m, d);
    check("refetch_miss", 32'(m), 32'(1));
    check("refetch_data", d, 32'h100);
    check("refetch_words", 32'(sw_count - sw_before), 32'(64));

    // Displacement wrap: 0x3F hits after priming line 0, 0x40 misses
    apply_reset(2);
    do_fetch(32'h0, m, d);
    check("prime_miss", 32'(m), 32'(1));
    do_fetch(32'h3F, m, d);
    check("wrap3f_miss", 32'(m), 32'(0));
    check("wrap3f_data", d, 32'h3F);
    do_fetch(32'h40, m, d);
    check("wrap40_miss", 32'(m), 32'(1));
    check("wrap40_data", d, 32'h40);

    check("max_outstanding_ok", 32'(max_q <= MAX_OUTSTANDING), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
